// File: rtl/register_file_n.sv
// register_file_n
//   Multi-ported register file with write-to-read bypass and a per-register
//   pending (scoreboard) bit used to detect read-after-issue hazards.
//
// Parameters
//   WIDTH    : data width in bits
//   DEPTH    : number of registers (power of two, >= 2)
//   ZERO_REG : when 1, register 0 reads as zero and is never pending
//
// Ports
//   clk      in   clock, all state changes on rising edge
//   rst      in   asynchronous active-high reset
//   ra, rb   in   read addresses, ports A and B
//   wr       in   write address
//   wrd      in   write data
//   reg_en   in   write enable (also completes the pending entry at wr)
//   iss_en   in   issue strobe, marks iss_addr pending
//   iss_addr in   destination of the issued instruction
//   flush    in   clears every pending bit
//   a, b     out  read data (combinational, with bypass)
//   busy_a/b out  addressed register is pending and not being written now
//   stall    out  busy_a | busy_b
module register_file_n #(
    parameter int WIDTH    = 5,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    input  logic [AW-1:0]    wr,
    input  logic [WIDTH-1:0] wrd,
    input  logic             reg_en,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             flush,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             busy_a,
    output logic             busy_b,
    output logic             stall
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    logic zero_en;
    logic wr_ok;
    logic iss_ok;
    logic hit_a, hit_b;
    logic zero_a, zero_b;

    assign zero_en = (ZERO_REG != 0);
    // Writes/issues aimed at a hardwired-zero register are dropped.
    assign wr_ok   = reg_en && !(zero_en && (wr == '0));
    assign iss_ok  = iss_en && !(zero_en && (iss_addr == '0));

    assign hit_a   = reg_en && (wr == ra);
    assign hit_b   = reg_en && (wr == rb);
    assign zero_a  = zero_en && (ra == '0);
    assign zero_b  = zero_en && (rb == '0);

    // Clear (completing write) applied first, then set, so a new producer
    // issued in the same cycle supersedes the completion; flush overrides both.
    always_comb begin
        pend_d = pend_q;
        if (reg_en) begin
            pend_d[wr] = 1'b0;
        end
        if (iss_ok) begin
            pend_d[iss_addr] = 1'b1;
        end
        if (flush) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[wr] <= wrd;
            end
            pend_q <= pend_d;
        end
    end

    // Reads are combinational; the bypass is not gated by reset so a write
    // presented during reset is still visible on the read ports.
    always_comb begin
        a = regs_q[ra];
        b = regs_q[rb];
        if (hit_a) a = wrd;
        if (hit_b) b = wrd;
        if (zero_a) a = '0;
        if (zero_b) b = '0;
    end

    // A write landing this cycle resolves the hazard without waiting for the edge.
    assign busy_a = pend_q[ra] && !hit_a && !zero_a;
    assign busy_b = pend_q[rb] && !hit_b && !zero_b;
    assign stall  = busy_a || busy_b;

endmodule

// File: tb/tb_register_file_n.sv
module tb_register_file_n;

    // DUT 0: defaults (WIDTH=5, DEPTH=4, ZERO_REG=0)
    logic       clk;
    logic       rst;
    logic [1:0] ra, rb, wr, iss_addr;
    logic [4:0] wrd;
    logic       reg_en, iss_en, flush;
    logic [4:0] a, b;
    logic       busy_a, busy_b, stall;

    // DUT 1: ZERO_REG=1, WIDTH=8, DEPTH=8
    logic [2:0] z_ra, z_rb, z_wr, z_iss_addr;
    logic [7:0] z_wrd;
    logic       z_reg_en, z_iss_en, z_flush;
    logic [7:0] z_a, z_b;
    logic       z_busy_a, z_busy_b, z_stall;

    register_file_n dut (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb), .wr(wr), .wrd(wrd),
        .reg_en(reg_en), .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .a(a), .b(b), .busy_a(busy_a), .busy_b(busy_b), .stall(stall)
    );

    register_file_n #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .ra(z_ra), .rb(z_rb), .wr(z_wr), .wrd(z_wrd),
        .reg_en(z_reg_en), .iss_en(z_iss_en), .iss_addr(z_iss_addr), .flush(z_flush),
        .a(z_a), .b(z_b), .busy_a(z_busy_a), .busy_b(z_busy_b), .stall(z_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {S_A, S_B, S_BA, S_BB, S_ST, S_ZA, S_ZB, S_ZBA, S_ZST} sig_e;

    typedef struct {
        string      tag;
        sig_e       sig;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] observe(input sig_e s);
        case (s)
            S_A:     return {3'b0, a};
            S_B:     return {3'b0, b};
            S_BA:    return {7'b0, busy_a};
            S_BB:    return {7'b0, busy_b};
            S_ST:    return {7'b0, stall};
            S_ZA:    return z_a;
            S_ZB:    return z_b;
            S_ZBA:   return {7'b0, z_busy_a};
            S_ZST:   return {7'b0, z_stall};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input sig_e s, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // Let combinational outputs settle mid-cycle, then retire every queued expectation.
    task automatic drain();
        exp_t e;
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, observe(e.sig), e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_en = 0; iss_en = 0; flush = 0;
        z_reg_en = 0; z_iss_en = 0; z_flush = 0;
    endtask

    initial begin
        rst = 1;
        ra = 0; rb = 0; wr = 0; iss_addr = 0; wrd = 0;
        z_ra = 0; z_rb = 0; z_wr = 0; z_iss_addr = 0; z_wrd = 0;
        idle();
        #2;
        expect_val("rst_a", S_A, 0);
        expect_val("rst_b", S_B, 0);
        expect_val("rst_busy_a", S_BA, 0);
        expect_val("rst_busy_b", S_BB, 0);
        expect_val("rst_stall", S_ST, 0);
        expect_val("rst_z_a", S_ZA, 0);
        drain();

        // Bypass stays live during reset, but the write itself is discarded.
        reg_en = 1; wr = 1; wrd = 5'h07; ra = 1; rb = 2;
        expect_val("rst_bypass_a", S_A, 8'h07);
        expect_val("rst_bypass_b", S_B, 0);
        drain();
        step();
        reg_en = 0;
        expect_val("rst_write_dropped", S_A, 0);
        drain();
        @(negedge clk);
        rst = 0;
        step();

        // Basic write / read
        reg_en = 1; wr = 2; wrd = 5'h1A; step();
        wr = 3; wrd = 5'h05; step();
        reg_en = 0; ra = 2; rb = 3;
        expect_val("rd_a_r2", S_A, 8'h1A);
        expect_val("rd_b_r3", S_B, 8'h05);
        drain();

        // Bypass on both ports
        reg_en = 1; wr = 1; wrd = 5'h03; step();
        reg_en = 0; ra = 1; rb = 1;
        expect_val("r1_init", S_A, 8'h03);
        drain();
        reg_en = 1; wr = 1; wrd = 5'h1F;
        expect_val("byp_a", S_A, 8'h1F);
        expect_val("byp_b", S_B, 8'h1F);
        drain();
        step();
        reg_en = 0;
        expect_val("byp_keep_a", S_A, 8'h1F);
        expect_val("byp_keep_b", S_B, 8'h1F);
        drain();

        // Scoreboard set / resolve
        iss_en = 1; iss_addr = 2; step();
        iss_en = 0; ra = 2; rb = 3;
        expect_val("sb_busy_a", S_BA, 1);
        expect_val("sb_busy_b", S_BB, 0);
        expect_val("sb_stall", S_ST, 1);
        drain();
        reg_en = 1; wr = 2; wrd = 5'h0A;
        expect_val("sb_resolve_busy", S_BA, 0);
        expect_val("sb_resolve_stall", S_ST, 0);
        expect_val("sb_resolve_a", S_A, 8'h0A);
        drain();
        step();
        reg_en = 0;
        expect_val("sb_cleared", S_BA, 0);
        expect_val("sb_data", S_A, 8'h0A);
        drain();

        // Set wins over clear at the same address
        iss_en = 1; iss_addr = 3; step();
        iss_en = 1; iss_addr = 3; reg_en = 1; wr = 3; wrd = 5'h11; step();
        idle(); ra = 0; rb = 3;
        expect_val("setwin_busy", S_BB, 1);
        expect_val("setwin_data", S_B, 8'h11);
        drain();

        // Flush beats set, register write still happens
        iss_en = 1; iss_addr = 1; step();
        iss_addr = 2; step();
        iss_en = 0; ra = 1; rb = 2;
        expect_val("pre_flush_a", S_BA, 1);
        expect_val("pre_flush_b", S_BB, 1);
        drain();
        flush = 1; iss_en = 1; iss_addr = 1; reg_en = 1; wr = 0; wrd = 5'h15; step();
        idle();
        expect_val("flush_busy_a", S_BA, 0);
        expect_val("flush_busy_b", S_BB, 0);
        expect_val("flush_stall", S_ST, 0);
        drain();
        ra = 0; rb = 3;
        expect_val("flush_write", S_A, 8'h15);
        expect_val("flush_busy_r3", S_BB, 0);
        drain();

        // Distinct registers, no aliasing of DEPTH-1
        reg_en = 1;
        wr = 0; wrd = 5'h01; step();
        wr = 1; wrd = 5'h02; step();
        wr = 2; wrd = 5'h04; step();
        wr = 3; wrd = 5'h0C; step();
        wr = 3; wrd = 5'h08; step();
        reg_en = 0;
        for (int i = 0; i < 4; i++) begin
            ra = 2'(i); rb = 2'(3 - i);
            expect_val($sformatf("alias_a%0d", i), S_A, 8'(1 << i));
            expect_val($sformatf("alias_b%0d", i), S_B, 8'(1 << (3 - i)));
            drain();
        end

        // Reset between edges with pending state
        iss_en = 1; iss_addr = 2; step();
        idle(); ra = 2; rb = 3;
        expect_val("pre_rst_busy", S_BA, 1);
        drain();
        rst = 1;
        #1;
        expect_val("mid_rst_a", S_A, 0);
        expect_val("mid_rst_b", S_B, 0);
        expect_val("mid_rst_busy", S_BA, 0);
        drain();
        rst = 0;
        step();
        expect_val("post_rst_a", S_A, 0);
        expect_val("post_rst_stall", S_ST, 0);
        drain();

        // ZERO_REG instance
        z_reg_en = 1; z_wr = 0; z_wrd = 8'hFF; z_ra = 0;
        expect_val("z_bypass_r0", S_ZA, 0);
        drain();
        step();
        z_reg_en = 0; z_iss_en = 1; z_iss_addr = 0; step();
        z_iss_en = 0;
        expect_val("z_r0_data", S_ZA, 0);
        expect_val("z_r0_busy", S_ZBA, 0);
        expect_val("z_r0_stall", S_ZST, 0);
        drain();
        z_reg_en = 1; z_wr = 7; z_wrd = 8'hAB; step();
        z_reg_en = 0; z_rb = 7; z_ra = 6;
        expect_val("z_r7", S_ZB, 8'hAB);
        expect_val("z_r6", S_ZA, 0);
        drain();

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
